sdp_mem_request_arb: RTL and testbench
======================================

# sdp_mem_request_arb

Round-robin arbiter that shares the single main memory controller (MMC) request port between several storage-descriptor processors: memory read controllers and the memory write controller. Each requester's multi-beat request transaction (SOM…EOM) is held atomically on the MMC port. The arbiter records grant order in an owner FIFO, so in-order MMC responses are steered back to the requester that issued them. It sits between the `sdp_cntl` request outputs and the MMC request input in the manager.

## Interface
Parameters
- NUM_REQ, 3, number of requesters (2..8)
- OWNER_FIFO_DEPTH, 8, outstanding request beats tracked (power of 2)

Ports
- clk  in  1  clock; all logic rising-edge
- reset_poweron  in  1  asynchronous, active-low reset
- req__arb__valid  in  [NUM_REQ-1:0]  per-requester request valid
- req__arb__cntl  in  NUM_REQ x [`COMMON_STD_INTF_CNTL_RANGE]  SOM/MOM/EOM/SOM_EOM framing
- req__arb__channel / bank / page / word  in  NUM_REQ x [`MGR_DRAM_CHANNEL/BANK/PAGE/WORD_ADDRESS_RANGE]  request address
- arb__req__ready  out  [NUM_REQ-1:0]  beat accepted when valid&ready
- arb__mmc__valid  out  1  registered request valid to MMC
- arb__mmc__cntl, channel, bank, page, word  out  same widths  registered request fields
- mmc__arb__ready  in  1  MMC accepts beat when valid&ready
- mmc__arb__resp_valid  in  1  one pulse per returned line, in request order
- arb__req__resp_valid  out  [NUM_REQ-1:0]  one-hot steer of resp_valid to owner
- arb__sys__owner_err  out  1  sticky: response with empty owner FIFO

## Operation
- State: IDLE, LOCKED. Registers: grant_id, rr_ptr, output stage, owner FIFO, err.
- IDLE: if any valid, grant_id ← first valid requester at or after rr_ptr (cyclic), → LOCKED. Arbitration cycle accepts no beat.
- LOCKED: arb__req__ready[grant_id] = (~arb__mmc__valid | mmc__arb__ready) & ~fifo_full. All other ready bits 0.
- Accepted beat loads the output stage and pushes grant_id into owner FIFO (one entry per beat).
- Accepted beat with cntl EOM or SOM_EOM: rr_ptr ← grant_id+1 (mod NUM_REQ), → IDLE.
- Framing errors (MOM/EOM without SOM) are not checked; the lock holds until EOM.
- Output stage: arb__mmc__valid cleared when mmc__arb__ready & ~new beat; holds fields while stalled.
- Response: mmc__arb__resp_valid pops the FIFO; arb__req__resp_valid = onehot(head) in same cycle, combinational from head. Pop on empty: no pop, all-zero steer, err ← 1.
- Push and pop in the same cycle: both occur, count unchanged. Full gates ready; push on full never occurs.
- Pointer wrap: FIFO pointers one bit wider than log2(depth); full/empty from MSB compare.

## Timing
- Reset values: arb__req__ready 0, arb__mmc__valid 0, cntl/address outputs 0, resp_valid 0, err 0, rr_ptr 0, state IDLE, FIFO empty.
- Reset asserted mid-transaction: all state cleared asynchronously; in-flight beats and owners are discarded.
- Grant latency: valid at cycle t in IDLE → ready high at t+1 → MMC valid at t+2.
- Throughput while LOCKED and MMC ready: one beat per cycle.
- Between transactions: one idle (arbitration) cycle.
- Response steer: zero-cycle combinational.

## Structure
- Shared `sdp_cntl.vh`: SDP_ARB_STATE_IDLE/LOCKED encodings, SDP_ARB_NUM_REQ, SDP_ARB_OWNER_FIFO_DEPTH defaults.
- Sub-module `sdp_arb_owner_fifo`: synchronous FIFO of $clog2(NUM_REQ)-bit IDs with push/pop/full/empty.
- Round-robin pick: combinational function in the top module.

## Test plan
- Single requester 1, 3-beat SOM/MOM/EOM, MMC always ready → MMC valid at t+2..t+4 with addresses in order; FIFO holds 1,1,1; three resp pulses → resp_valid=3'b010 each.
- Requesters 0 and 2 both valid from reset → 0 granted first; after EOM, 2 granted; rr_ptr=0 after 2's EOM; no interleaved beats on MMC.
- MMC ready low 5 cycles mid-transaction → output fields stable, arb__req__ready low, no beat lost or duplicated.
- 8 SOM_EOM beats with no responses (depth 8) → ready low on 9th; one resp pulse in the same cycle as a blocked attempt → ready returns next cycle.
- resp_valid pulse with empty FIFO → resp_valid=0, err=1 sticky until reset.
- Assert reset while LOCKED with 3 beats outstanding → all outputs 0 immediately; after release a new SOM_EOM from requester 2 is granted normally and the FIFO holds only its ID.

Source files
------------

// File: rtl/sdp_mem_request_arb_pkg.sv
// Shared encodings and default sizing for the SDP memory request arbiter.
// Field widths stand in for the manager's DRAM address and std-interface control ranges.
package sdp_mem_request_arb_pkg;

    localparam int SDP_ARB_NUM_REQ          = 3;
    localparam int SDP_ARB_OWNER_FIFO_DEPTH = 8;

    localparam logic [0:0] SDP_ARB_STATE_IDLE   = 1'b0;
    localparam logic [0:0] SDP_ARB_STATE_LOCKED = 1'b1;

    localparam int CNTL_W = 2;
    localparam int CHAN_W = 2;
    localparam int BANK_W = 3;
    localparam int PAGE_W = 12;
    localparam int WORD_W = 5;

    localparam logic [CNTL_W-1:0] CNTL_MOM     = 2'b00;
    localparam logic [CNTL_W-1:0] CNTL_SOM     = 2'b01;
    localparam logic [CNTL_W-1:0] CNTL_EOM     = 2'b10;
    localparam logic [CNTL_W-1:0] CNTL_SOM_EOM = 2'b11;

    function automatic logic cntl_ends_txn(input logic [CNTL_W-1:0] cntl);
        return (cntl == CNTL_EOM) || (cntl == CNTL_SOM_EOM);
    endfunction

endpackage

// File: rtl/sdp_arb_owner_fifo.sv
// Owner-ID FIFO recording which requester issued each MMC beat; head is combinational.
// Pointers carry an extra wrap bit so full and empty are distinguished without a counter.
module sdp_arb_owner_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_poweron,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;

    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_dat_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i && !full_o) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_i && !empty_o) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !full_o) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
        end
    end

endmodule

// File: rtl/sdp_mem_request_arb.sv
// Round-robin arbiter sharing the MMC request port; each SOM..EOM transaction is held atomically.
// Grant -> ready one cycle later -> MMC valid the cycle after; responses steered by owner FIFO order.
module sdp_mem_request_arb
    import sdp_mem_request_arb_pkg::*;
#(
    parameter int NUM_REQ          = SDP_ARB_NUM_REQ,
    parameter int OWNER_FIFO_DEPTH = SDP_ARB_OWNER_FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      reset_poweron,
    input  logic [NUM_REQ-1:0]        req__arb__valid,
    input  logic [NUM_REQ*CNTL_W-1:0] req__arb__cntl,
    input  logic [NUM_REQ*CHAN_W-1:0] req__arb__channel,
    input  logic [NUM_REQ*BANK_W-1:0] req__arb__bank,
    input  logic [NUM_REQ*PAGE_W-1:0] req__arb__page,
    input  logic [NUM_REQ*WORD_W-1:0] req__arb__word,
    output logic [NUM_REQ-1:0]        arb__req__ready,
    output logic                      arb__mmc__valid,
    output logic [CNTL_W-1:0]         arb__mmc__cntl,
    output logic [CHAN_W-1:0]         arb__mmc__channel,
    output logic [BANK_W-1:0]         arb__mmc__bank,
    output logic [PAGE_W-1:0]         arb__mmc__page,
    output logic [WORD_W-1:0]         arb__mmc__word,
    input  logic                      mmc__arb__ready,
    input  logic                      mmc__arb__resp_valid,
    output logic [NUM_REQ-1:0]        arb__req__resp_valid,
    output logic                      arb__sys__owner_err
);
    localparam int IDW = $clog2(NUM_REQ);

    // First valid requester at or after ptr, searching cyclically.
    function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] vld, input logic [IDW-1:0] ptr);
        logic [IDW-1:0] pick;
        logic [IDW-1:0] idx;
        logic           found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IDW'((int'(ptr) + i) % NUM_REQ);
            if (!found && vld[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    logic [0:0]     state_q, state_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic           mmc_vld_q;
    logic [CNTL_W-1:0] mmc_cntl_q;
    logic [CHAN_W-1:0] mmc_chan_q;
    logic [BANK_W-1:0] mmc_bank_q;
    logic [PAGE_W-1:0] mmc_page_q;
    logic [WORD_W-1:0] mmc_word_q;
    logic           err_q;

    logic           fifo_full, fifo_empty, slot_free, beat_acc, resp_pop;
    logic [IDW-1:0] fifo_head;
    logic [CNTL_W-1:0] sel_cntl;
    logic [CHAN_W-1:0] sel_chan;
    logic [BANK_W-1:0] sel_bank;
    logic [PAGE_W-1:0] sel_page;
    logic [WORD_W-1:0] sel_word;

    always_comb begin
        sel_cntl = '0;
        sel_chan = '0;
        sel_bank = '0;
        sel_page = '0;
        sel_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == IDW'(i)) begin
                sel_cntl = req__arb__cntl[i*CNTL_W +: CNTL_W];
                sel_chan = req__arb__channel[i*CHAN_W +: CHAN_W];
                sel_bank = req__arb__bank[i*BANK_W +: BANK_W];
                sel_page = req__arb__page[i*PAGE_W +: PAGE_W];
                sel_word = req__arb__word[i*WORD_W +: WORD_W];
            end
        end
    end

    // A beat may enter only if the output stage drains this cycle and an owner slot is free.
    assign slot_free = (~mmc_vld_q | mmc__arb__ready) & ~fifo_full;
    assign beat_acc  = (state_q == SDP_ARB_STATE_LOCKED) & slot_free & req__arb__valid[grant_q];

    always_comb begin
        arb__req__ready = '0;
        if (state_q == SDP_ARB_STATE_LOCKED) begin
            arb__req__ready[grant_q] = slot_free;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        if (state_q == SDP_ARB_STATE_IDLE) begin
            if (|req__arb__valid) begin
                grant_d = rr_pick(req__arb__valid, rr_ptr_q);
                state_d = SDP_ARB_STATE_LOCKED;
            end
        end else if (beat_acc && cntl_ends_txn(sel_cntl)) begin
            rr_ptr_d = (grant_q == IDW'(NUM_REQ-1)) ? '0 : grant_q + 1'b1;
            state_d  = SDP_ARB_STATE_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            state_q    <= SDP_ARB_STATE_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            mmc_vld_q  <= 1'b0;
            mmc_cntl_q <= '0;
            mmc_chan_q <= '0;
            mmc_bank_q <= '0;
            mmc_page_q <= '0;
            mmc_word_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            if (beat_acc) begin
                mmc_vld_q  <= 1'b1;
                mmc_cntl_q <= sel_cntl;
                mmc_chan_q <= sel_chan;
                mmc_bank_q <= sel_bank;
                mmc_page_q <= sel_page;
                mmc_word_q <= sel_word;
            end else if (mmc__arb__ready) begin
                mmc_vld_q <= 1'b0;
            end
            if (mmc__arb__resp_valid && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    sdp_arb_owner_fifo #(
        .WIDTH (IDW),
        .DEPTH (OWNER_FIFO_DEPTH)
    ) u_owner_fifo (
        .clk           (clk),
        .reset_poweron (reset_poweron),
        .push_i        (beat_acc),
        .push_dat_i    (grant_q),
        .pop_i         (resp_pop),
        .head_dat_o    (fifo_head),
        .full_o        (fifo_full),
        .empty_o       (fifo_empty)
    );

    assign resp_pop             = mmc__arb__resp_valid & ~fifo_empty;
    assign arb__req__resp_valid = resp_pop ? (NUM_REQ'(1) << fifo_head) : '0;

    assign arb__mmc__valid     = mmc_vld_q;
    assign arb__mmc__cntl      = mmc_cntl_q;
    assign arb__mmc__channel   = mmc_chan_q;
    assign arb__mmc__bank      = mmc_bank_q;
    assign arb__mmc__page      = mmc_page_q;
    assign arb__mmc__word      = mmc_word_q;
    assign arb__sys__owner_err = err_q;

endmodule

// File: tb/tb_sdp_mem_request_arb.sv
// Bench for sdp_mem_request_arb: cycle table, directed corner sequences and randomized traffic
// scored against a transaction-level round-robin plan and an owner-order queue.
module tb_sdp_mem_request_arb;
    import sdp_mem_request_arb_pkg::*;

    localparam int NR    = SDP_ARB_NUM_REQ;
    localparam int DEPTH = SDP_ARB_OWNER_FIFO_DEPTH;
    localparam int IDW   = $clog2(NR);

    typedef struct packed {
        logic [IDW-1:0]    id;
        logic [CNTL_W-1:0] cntl;
        logic [CHAN_W-1:0] chan;
        logic [BANK_W-1:0] bank;
        logic [PAGE_W-1:0] page;
        logic [WORD_W-1:0] word;
    } beat_t;

    typedef struct {
        logic [2:0]        vld;
        logic [CNTL_W-1:0] cntl;
        logic [WORD_W-1:0] word;
        logic              mrdy;
        logic              resp;
        logic [2:0]        e_rdy;
        logic              e_mvld;
        logic [CNTL_W-1:0] e_mcntl;
        logic [WORD_W-1:0] e_mword;
        logic [2:0]        e_resp;
        logic              e_err;
    } vec_t;

    logic clk = 1'b0;
    logic reset_poweron = 1'b1;
    logic [NR-1:0]        req_vld;
    logic [NR*CNTL_W-1:0] req_cntl;
    logic [NR*CHAN_W-1:0] req_chan;
    logic [NR*BANK_W-1:0] req_bank;
    logic [NR*PAGE_W-1:0] req_page;
    logic [NR*WORD_W-1:0] req_word;
    logic [NR-1:0]        arb_rdy;
    logic                 mmc_vld;
    logic [CNTL_W-1:0]    mmc_cntl;
    logic [CHAN_W-1:0]    mmc_chan;
    logic [BANK_W-1:0]    mmc_bank;
    logic [PAGE_W-1:0]    mmc_page;
    logic [WORD_W-1:0]    mmc_word;
    logic                 mmc_rdy;
    logic                 mmc_resp;
    logic [NR-1:0]        steer;
    logic                 err;

    int    checks   = 0;
    int    passed   = 0;
    int    n_mmc    = 0;
    int    rr_model = 0;
    logic  exp_err  = 1'b0;
    beat_t req_q [NR][$];
    beat_t exp_q [$];
    logic [IDW-1:0] own_q [$];
    vec_t  vecs [11];

    always #5 clk = ~clk;

    sdp_mem_request_arb dut (
        .clk                  (clk),
        .reset_poweron        (reset_poweron),
        .req__arb__valid      (req_vld),
        .req__arb__cntl       (req_cntl),
        .req__arb__channel    (req_chan),
        .req__arb__bank       (req_bank),
        .req__arb__page       (req_page),
        .req__arb__word       (req_word),
        .arb__req__ready      (arb_rdy),
        .arb__mmc__valid      (mmc_vld),
        .arb__mmc__cntl       (mmc_cntl),
        .arb__mmc__channel    (mmc_chan),
        .arb__mmc__bank       (mmc_bank),
        .arb__mmc__page       (mmc_page),
        .arb__mmc__word       (mmc_word),
        .mmc__arb__ready      (mmc_rdy),
        .mmc__arb__resp_valid (mmc_resp),
        .arb__req__resp_valid (steer),
        .arb__sys__owner_err  (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] mmc_fields();
        return 32'({mmc_cntl, mmc_chan, mmc_bank, mmc_page, mmc_word});
    endfunction

    function automatic logic [31:0] beat_fields(input beat_t b);
        return 32'({b.cntl, b.chan, b.bank, b.page, b.word});
    endfunction

    task automatic clear_inputs();
        req_vld  = '0;
        req_cntl = '0;
        req_chan = '0;
        req_bank = '0;
        req_page = '0;
        req_word = '0;
        mmc_rdy  = 1'b0;
        mmc_resp = 1'b0;
    endtask

    // Asserts reset mid-cycle, checks outputs clear at once, then clears the bench model.
    task automatic do_reset();
        #2;
        reset_poweron = 1'b0;
        mmc_resp = 1'b1;
        #1;
        chk("rst_ready", 32'(arb_rdy), 0);
        chk("rst_mmc_valid", 32'(mmc_vld), 0);
        chk("rst_mmc_fields", mmc_fields(), 0);
        chk("rst_resp_steer", 32'(steer), 0);
        chk("rst_owner_err", 32'(err), 0);
        clear_inputs();
        for (int r = 0; r < NR; r++) req_q[r].delete();
        exp_q.delete();
        own_q.delete();
        exp_err  = 1'b0;
        rr_model = 0;
        n_mmc    = 0;
        @(negedge clk);
        reset_poweron = 1'b1;
    endtask

    task automatic add_txn(input int r, input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.id   = IDW'(r);
            b.cntl = (n == 1) ? CNTL_SOM_EOM : (i == 0) ? CNTL_SOM : (i == n-1) ? CNTL_EOM : CNTL_MOM;
            b.chan = CHAN_W'($urandom);
            b.bank = BANK_W'($urandom);
            b.page = PAGE_W'($urandom);
            b.word = WORD_W'(i + 8*r);
            req_q[r].push_back(b);
        end
    endtask

    // Transaction-level schedule: whole transactions, round robin over requesters with work pending.
    task automatic plan();
        beat_t cp [NR][$];
        beat_t b;
        int    r;
        bit    found, last;
        r = 0;
        for (int i = 0; i < NR; i++) cp[i] = req_q[i];
        found = 1'b1;
        while (found) begin
            found = 1'b0;
            for (int k = 0; k < NR && !found; k++) begin
                r = (rr_model + k) % NR;
                if (cp[r].size() > 0) found = 1'b1;
            end
            if (found) begin
                last = 1'b0;
                while (!last && cp[r].size() > 0) begin
                    b = cp[r].pop_front();
                    exp_q.push_back(b);
                    last = (b.cntl == CNTL_EOM) || (b.cntl == CNTL_SOM_EOM);
                end
                rr_model = (r + 1) % NR;
            end
        end
    endtask

    task automatic run_cycle(input logic rdy, input logic resp);
        beat_t b;
        logic [NR-1:0] e_steer;
        @(negedge clk);
        for (int r = 0; r < NR; r++) begin
            b = '0;
            if (req_q[r].size() > 0) b = req_q[r][0];
            req_vld[r] = (req_q[r].size() > 0);
            req_cntl[r*CNTL_W +: CNTL_W] = b.cntl;
            req_chan[r*CHAN_W +: CHAN_W] = b.chan;
            req_bank[r*BANK_W +: BANK_W] = b.bank;
            req_page[r*PAGE_W +: PAGE_W] = b.page;
            req_word[r*WORD_W +: WORD_W] = b.word;
        end
        mmc_rdy  = rdy;
        mmc_resp = resp;
        #1;
        chk("owner_err", 32'(err), 32'(exp_err));
        if (own_q.size() == DEPTH) chk("full_blocks_ready", 32'(arb_rdy), 0);
        if (resp) begin
            e_steer = '0;
            if (own_q.size() > 0) e_steer[own_q.pop_front()] = 1'b1;
            else exp_err = 1'b1;
            chk("resp_steer", 32'(steer), 32'(e_steer));
        end
        for (int r = 0; r < NR; r++) begin
            if (req_vld[r] && arb_rdy[r]) begin
                void'(req_q[r].pop_front());
                own_q.push_back(IDW'(r));
            end
        end
        if (mmc_vld && rdy) begin
            n_mmc++;
            if (exp_q.size() == 0) chk("mmc_extra_beat", 32'(mmc_vld), 0);
            else chk("mmc_beat", mmc_fields(), beat_fields(exp_q.pop_front()));
        end
    endtask

    task automatic drain(input int budget, input bit rnd);
        int  c;
        bit  busy;
        logic rdy, resp;
        c = 0;
        busy = 1'b1;
        while (busy && c < budget) begin
            rdy  = rnd ? ($urandom_range(0, 9) < 7) : 1'b1;
            resp = rnd ? ((own_q.size() > 0) && ($urandom_range(0, 9) < 4)) : 1'b0;
            run_cycle(rdy, resp);
            c++;
            busy = (exp_q.size() > 0);
            for (int r = 0; r < NR; r++) if (req_q[r].size() > 0) busy = 1'b1;
        end
        chk("drain_complete", 32'(exp_q.size()), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [NR-1:0] e_rdy;
        clear_inputs();

        //          vld     cntl          word mrdy resp  e_rdy  mv e_mcntl   e_mword e_resp  err
        vecs[0]  = '{3'b010, CNTL_SOM,    5'd4, 1'b1, 1'b0, 3'b000, 1'b0, CNTL_MOM, 5'd0, 3'b000, 1'b0};
        vecs[1]  = '{3'b010, CNTL_SOM,    5'd4, 1'b1, 1'b0, 3'b010, 1'b0, CNTL_MOM, 5'd0, 3'b000, 1'b0};
        vecs[2]  = '{3'b010, CNTL_MOM,    5'd5, 1'b1, 1'b0, 3'b010, 1'b1, CNTL_SOM, 5'd4, 3'b000, 1'b0};
        vecs[3]  = '{3'b010, CNTL_EOM,    5'd6, 1'b1, 1'b0, 3'b010, 1'b1, CNTL_MOM, 5'd5, 3'b000, 1'b0};
        vecs[4]  = '{3'b000, CNTL_MOM,    5'd0, 1'b1, 1'b0, 3'b000, 1'b1, CNTL_EOM, 5'd6, 3'b000, 1'b0};
        vecs[5]  = '{3'b000, CNTL_MOM,    5'd0, 1'b1, 1'b1, 3'b000, 1'b0, CNTL_MOM, 5'd0, 3'b010, 1'b0};
        vecs[6]  = '{3'b000, CNTL_MOM,    5'd0, 1'b1, 1'b1, 3'b000, 1'b0, CNTL_MOM, 5'd0, 3'b010, 1'b0};
        vecs[7]  = '{3'b000, CNTL_MOM,    5'd0, 1'b1, 1'b1, 3'b000, 1'b0, CNTL_MOM, 5'd0, 3'b010, 1'b0};
        vecs[8]  = '{3'b000, CNTL_MOM,    5'd0, 1'b1, 1'b1, 3'b000, 1'b0, CNTL_MOM, 5'd0, 3'b000, 1'b0};
        vecs[9]  = '{3'b000, CNTL_MOM,    5'd0, 1'b1, 1'b0, 3'b000, 1'b0, CNTL_MOM, 5'd0, 3'b000, 1'b1};
        vecs[10] = '{3'b000, CNTL_MOM,    5'd0, 1'b0, 1'b0, 3'b000, 1'b0, CNTL_MOM, 5'd0, 3'b000, 1'b1};

        do_reset();

        // Single requester 1, three beats, then responses and a pop on empty.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            clear_inputs();
            req_vld = vecs[i].vld;
            req_cntl[CNTL_W +: CNTL_W] = vecs[i].cntl;
            req_word[WORD_W +: WORD_W] = vecs[i].word;
            mmc_rdy  = vecs[i].mrdy;
            mmc_resp = vecs[i].resp;
            #1;
            chk($sformatf("row%0d_ready", i), 32'(arb_rdy), 32'(vecs[i].e_rdy));
            chk($sformatf("row%0d_mmc_valid", i), 32'(mmc_vld), 32'(vecs[i].e_mvld));
            if (vecs[i].e_mvld) begin
                chk($sformatf("row%0d_mmc_cntl", i), 32'(mmc_cntl), 32'(vecs[i].e_mcntl));
                chk($sformatf("row%0d_mmc_word", i), 32'(mmc_word), 32'(vecs[i].e_mword));
            end
            chk($sformatf("row%0d_resp_steer", i), 32'(steer), 32'(vecs[i].e_resp));
            chk($sformatf("row%0d_owner_err", i), 32'(err), 32'(vecs[i].e_err));
        end

        // Requesters 0 and 2 contend; 2 must win the second slot, then 0 again.
        do_reset();
        add_txn(0, 2);
        add_txn(2, 3);
        add_txn(0, 1);
        plan();
        drain(100, 1'b0);

        // MMC stall for five cycles in the middle of a four-beat transaction.
        do_reset();
        add_txn(1, 4);
        plan();
        for (int c = 0; c < 20 && n_mmc < 1; c++) run_cycle(1'b1, 1'b0);
        for (int s = 0; s < 5; s++) begin
            run_cycle(1'b0, 1'b0);
            chk("stall_ready_low", 32'(arb_rdy), 0);
            chk("stall_valid_held", 32'(mmc_vld), 1);
            if (exp_q.size() > 0) chk("stall_fields_stable", mmc_fields(), beat_fields(exp_q[0]));
        end
        drain(50, 1'b0);

        // Fill the owner FIFO with eight single-beat requests, then free one slot.
        do_reset();
        for (int k = 0; k < 3; k++) for (int r = 0; r < NR; r++) add_txn(r, 1);
        plan();
        for (int c = 0; c < 60 && own_q.size() < DEPTH; c++) run_cycle(1'b1, 1'b0);
        chk("owner_fifo_filled", 32'(own_q.size()), DEPTH);
        for (int c = 0; c < 3; c++) begin
            run_cycle(1'b1, 1'b0);
            chk("ninth_beat_blocked", 32'(arb_rdy), 0);
        end
        run_cycle(1'b1, 1'b1);
        chk("blocked_during_pop", 32'(arb_rdy), 0);
        run_cycle(1'b1, 1'b0);
        e_rdy = '0;
        if (exp_q.size() > 0) e_rdy[exp_q[0].id] = 1'b1;
        chk("ready_after_pop", 32'(arb_rdy), 32'(e_rdy));

        // Reset while three beats of a transaction are outstanding.
        do_reset();
        add_txn(1, 5);
        plan();
        for (int c = 0; c < 20 && own_q.size() < 3; c++) run_cycle(1'b1, 1'b0);
        do_reset();
        add_txn(2, 1);
        plan();
        drain(20, 1'b0);
        run_cycle(1'b1, 1'b1);
        run_cycle(1'b1, 1'b1);
        run_cycle(1'b1, 1'b0);
        chk("post_reset_sticky_err", 32'(err), 1);

        // Randomized traffic with random MMC backpressure and response timing.
        do_reset();
        for (int round = 0; round < 25; round++) begin
            for (int r = 0; r < NR; r++) begin
                int ntx;
                ntx = $urandom_range(0, 3);
                for (int t = 0; t < ntx; t++) add_txn(r, $urandom_range(1, 4));
            end
            plan();
            drain(2000, 1'b1);
        end
        for (int c = 0; c < 200 && own_q.size() > 0; c++) run_cycle(1'b1, 1'b1);
        run_cycle(1'b1, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
